// File: rtl/door_sequencer.sv
// Garage-door supervisory sequencer: merges wall/remote requests, drives UP_M/DN_M,
// handles auto-reverse, travel watchdog and sticky FAULT. Optional auto-close: DOOR_AUTO_CLOSE_EN.
module door_sequencer #(
    parameter int CNT_W          = 16,
    parameter int TRAVEL_TIMEOUT = 500,
    parameter int AUTO_CLOSE_CYC = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Wall,
    input  logic       Btn_Remote,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_OPENING = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSING = 3'd3,
        S_STOPPED = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

`ifdef DOOR_AUTO_CLOSE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTO_CLOSE_CYC - 1);

    state_e           state_q, state_d;
    logic             last_dir_q, last_dir_d;  // 1 = last travel was up
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q;
    logic             req_lvl;
    logic             req;
    logic             travel_d;

    // A request is the rising edge of the OR, so overlapping presses merge into one.
    assign req_lvl = Btn_Wall | Btn_Remote;
    assign req     = req_lvl & ~req_q;

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        cnt_d      = cnt_q;
        travel_d   = 1'b0;

        if (state_q != S_FAULT && UP_Max && DN_Max) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_STOPPED: begin
                    if (req) state_d = last_dir_q ? S_CLOSING : S_OPENING;
                end
                S_CLOSED: begin
                    if (req && !UP_Max) state_d = S_OPENING;
                end
                S_OPENING: begin
                    if (UP_Max) begin
                        state_d = S_OPEN;
                    end else if (cnt_q == TRAVEL_LAST) begin
                        state_d = S_FAULT;
                    end else if (req) begin
                        state_d    = S_STOPPED;
                        last_dir_d = 1'b1;
                    end
                end
                S_OPEN: begin
                    if (req) begin
                        state_d = S_CLOSING;
                    end else if (AUTO_EN && cnt_q == AUTO_LAST && !Obstruct) begin
                        state_d = S_CLOSING;
                    end
                end
                S_CLOSING: begin
                    if (DN_Max) begin
                        state_d = S_CLOSED;
                    end else if (Obstruct) begin
                        state_d = S_OPENING;
                    end else if (cnt_q == TRAVEL_LAST) begin
                        state_d = S_FAULT;
                    end else if (req) begin
                        state_d    = S_STOPPED;
                        last_dir_d = 1'b0;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FAULT;
                end
            endcase
        end

        // Counter restarts on every entry into a timed state, including CLOSING->OPENING reversal.
        travel_d = (state_d == S_OPENING) || (state_d == S_CLOSING) || (state_d == S_OPEN);
        if (state_d != state_q && travel_d) begin
            cnt_d = '0;
        end else if (state_q == S_OPENING || state_q == S_CLOSING || state_q == S_OPEN) begin
            if (AUTO_EN && state_q == S_OPEN && Obstruct) begin
                cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_STOPPED;
            last_dir_q <= 1'b0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            cnt_q      <= cnt_d;
            req_q      <= req_lvl;
        end
    end

    assign UP_M  = (state_q == S_OPENING);
    assign DN_M  = (state_q == S_CLOSING);
    assign Fault = (state_q == S_FAULT);
    assign State = state_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with a cycle-level behavioural model compared every cycle.
module tb_door_sequencer;

    localparam int TO = 8;
    localparam int AC = 6;
`ifdef DOOR_AUTO_CLOSE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Btn_Wall = 1'b0, Btn_Remote = 1'b0;
    logic       UP_Max = 1'b0, DN_Max = 1'b0, Obstruct = 1'b0;
    logic       UP_M, DN_M, Fault;
    logic [2:0] State;

    int checks = 0;
    int failures = 0;

    door_sequencer #(.CNT_W(16), .TRAVEL_TIMEOUT(TO), .AUTO_CLOSE_CYC(AC)) dut (
        .CLK(CLK), .RST(RST), .Btn_Wall(Btn_Wall), .Btn_Remote(Btn_Remote),
        .UP_Max(UP_Max), .DN_Max(DN_Max), .Obstruct(Obstruct),
        .UP_M(UP_M), .DN_M(DN_M), .Fault(Fault), .State(State)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: door position code plus the cycle at which the current timing window began.
    int m_st = 4;
    bit m_up = 1'b0;
    bit m_prev = 1'b0;
    int cyc = 0;
    int m_ref = 0;
    bit lvl, rq;
    int nxt;

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            m_st = 4; m_up = 1'b0; m_prev = 1'b0; m_ref = cyc;
        end else begin
            lvl = Btn_Wall | Btn_Remote;
            rq = lvl & ~m_prev;
            m_prev = lvl;
            nxt = m_st;
            if (m_st != 5 && UP_Max && DN_Max) nxt = 5;
            else if (m_st == 4) begin
                if (rq) nxt = m_up ? 3 : 1;
            end else if (m_st == 0) begin
                if (rq && !UP_Max) nxt = 1;
            end else if (m_st == 1) begin
                if (UP_Max) nxt = 2;
                else if (cyc - m_ref == TO) nxt = 5;
                else if (rq) begin nxt = 4; m_up = 1'b1; end
            end else if (m_st == 2) begin
                if (rq) nxt = 3;
                else if (AUTO && !Obstruct && cyc - m_ref == AC) nxt = 3;
                else if (AUTO && Obstruct) m_ref = cyc;
            end else if (m_st == 3) begin
                if (DN_Max) nxt = 0;
                else if (Obstruct) nxt = 1;
                else if (cyc - m_ref == TO) nxt = 5;
                else if (rq) begin nxt = 4; m_up = 1'b0; end
            end
            if (nxt != m_st && (nxt == 1 || nxt == 2 || nxt == 3)) m_ref = cyc;
            m_st = nxt;
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("model_state", int'(State), m_st);
        chk("model_up_m", int'(UP_M), int'(m_st == 1));
        chk("model_dn_m", int'(DN_M), int'(m_st == 3));
        chk("model_fault", int'(Fault), int'(m_st == 5));
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc_n(2);
        RST = 1'b1;
        cyc_n(1);
    endtask

    task automatic press_wall();
        Btn_Wall = 1'b1;
        cyc_n(1);
        Btn_Wall = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_state", int'(State), 4);
        chk("reset_fault", int'(Fault), 0);
        chk("reset_motors", int'({UP_M, DN_M}), 0);

        // Basic open / close cycle.
        press_wall();
        chk("open_start", int'(State), 1);
        chk("open_up_m", int'(UP_M), 1);
        cyc_n(2); UP_Max = 1'b1; cyc_n(1);
        chk("open_reached", int'(State), 2);
        chk("open_up_m_off", int'(UP_M), 0);
        Btn_Remote = 1'b1; UP_Max = 1'b0; cyc_n(1); Btn_Remote = 1'b0;
        chk("close_start", int'(State), 3);
        chk("close_dn_m", int'(DN_M), 1);
        cyc_n(2); DN_Max = 1'b1; cyc_n(1);
        chk("closed_reached", int'(State), 0);
        chk("closed_dn_m_off", int'(DN_M), 0);

        // Obstruction reverses a closing door on the same edge.
        Btn_Wall = 1'b1; cyc_n(1); Btn_Wall = 1'b0; DN_Max = 1'b0;
        chk("reopen_from_closed", int'(State), 1);
        cyc_n(1); UP_Max = 1'b1; cyc_n(1); UP_Max = 1'b0;
        chk("open_again", int'(State), 2);
        press_wall();
        chk("closing_again", int'(State), 3);
        cyc_n(2); Obstruct = 1'b1; cyc_n(1); Obstruct = 1'b0;
        chk("obstruct_reverse", int'(State), 1);
        chk("obstruct_motors", int'({UP_M, DN_M}), 2);

        // Simultaneous press held for 5 cycles yields one stop; next press closes.
        cyc_n(1);
        Btn_Wall = 1'b1; Btn_Remote = 1'b1; cyc_n(1);
        chk("dual_press_stop", int'(State), 4);
        cyc_n(4);
        chk("dual_hold_stays_stopped", int'(State), 4);
        Btn_Wall = 1'b0; Btn_Remote = 1'b0; cyc_n(2);
        Btn_Remote = 1'b1; cyc_n(1); Btn_Remote = 1'b0;
        chk("stopped_then_close", int'(State), 3);
        DN_Max = 1'b1; cyc_n(1);
        chk("closed_after_stop", int'(State), 0);

        // Second button while first held is not a request; then travel watchdog.
        Btn_Wall = 1'b1; cyc_n(1); DN_Max = 1'b0;
        chk("watchdog_enter", int'(State), 1);
        Btn_Remote = 1'b1; cyc_n(1);
        chk("overlap_no_req", int'(State), 1);
        Btn_Wall = 1'b0; Btn_Remote = 1'b0;
        cyc_n(6);
        chk("watchdog_edge7", int'(State), 1);
        cyc_n(1);
        chk("watchdog_fault", int'(State), 5);
        chk("watchdog_fault_flag", int'(Fault), 1);
        chk("watchdog_motors", int'({UP_M, DN_M}), 0);
        press_wall(); cyc_n(1);
        chk("fault_ignores_btn", int'(State), 5);
        RST = 1'b0; #1;
        chk("fault_async_clear", int'(State), 4);
        chk("fault_flag_clear", int'(Fault), 0);
        cyc_n(1); RST = 1'b1; cyc_n(1);

        // Reset mid-travel drops the motor asynchronously; next request opens.
        press_wall();
        chk("midtravel_opening", int'(UP_M), 1);
        cyc_n(1);
        RST = 1'b0; #1;
        chk("midtravel_motor_drop", int'(UP_M), 0);
        chk("midtravel_state", int'(State), 4);
        cyc_n(1); RST = 1'b1; cyc_n(1);
        press_wall();
        chk("after_reset_opens", int'(State), 1);

        // Both limits: beats UP_Max->OPEN in OPENING, and applies in STOPPED.
        UP_Max = 1'b1; DN_Max = 1'b1; cyc_n(1);
        chk("both_limits_opening", int'(State), 5);
        chk("both_limits_motors", int'({UP_M, DN_M}), 0);
        UP_Max = 1'b0; DN_Max = 1'b0;
        do_reset();
        UP_Max = 1'b1; DN_Max = 1'b1; cyc_n(1);
        chk("both_limits_stopped", int'(State), 5);
        UP_Max = 1'b0; DN_Max = 1'b0;
        do_reset();

        // OPEN hold / auto-close.
        press_wall(); cyc_n(1); UP_Max = 1'b1; cyc_n(1); UP_Max = 1'b0;
        chk("hold_open_entry", int'(State), 2);
`ifdef DOOR_AUTO_CLOSE_EN
        cyc_n(5);
        chk("auto_close_pre", int'(State), 2);
        cyc_n(1);
        chk("auto_close_fire", int'(State), 3);
        DN_Max = 1'b1; cyc_n(1); DN_Max = 1'b0;
        chk("auto_close_closed", int'(State), 0);
        press_wall(); cyc_n(1); UP_Max = 1'b1; cyc_n(1); UP_Max = 1'b0;
        chk("obstruct_open_entry", int'(State), 2);
        Obstruct = 1'b1; cyc_n(20);
        chk("obstruct_holds_open", int'(State), 2);
        Obstruct = 1'b0; cyc_n(5);
        chk("obstruct_release_pre", int'(State), 2);
        cyc_n(1);
        chk("obstruct_release_close", int'(State), 3);
`else
        Obstruct = 1'b1; cyc_n(10); Obstruct = 1'b0;
        cyc_n(40);
        chk("open_holds_50", int'(State), 2);
        press_wall();
        chk("open_req_closes", int'(State), 3);
`endif
        cyc_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/door_sequencer.md
Name: door_sequencer

Overview:
- Supervisory controller for the garage-door motor pair (UP_M/DN_M) with limit switches UP_Max/DN_Max.
- Merges two requesters (wall button, remote) into one activate stream and sequences open/stop/close.
- Adds obstruction auto-reverse, a travel watchdog and a latched fault state.
- Sits between the user inputs and the motor drivers, replacing a bare single-Activate door FSM.

Parameters:
- CNT_W, 16, width of the shared cycle counter.
- TRAVEL_TIMEOUT, 500, max cycles in OPENING/CLOSING before FAULT; must be < 2^CNT_W.
- AUTO_CLOSE_CYC, 1000, cycles held in OPEN before auto-close; used only with DOOR_AUTO_CLOSE_EN.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- Btn_Wall  in  1  wall push-button, level, synchronous to CLK
- Btn_Remote  in  1  remote receiver output, level, synchronous to CLK
- UP_Max  in  1  upper limit switch, 1 = fully open
- DN_Max  in  1  lower limit switch, 1 = fully closed
- Obstruct  in  1  beam sensor, 1 = obstacle in path
- UP_M  out  1  raise motor enable
- DN_M  out  1  lower motor enable
- Fault  out  1  sticky fault flag
- State  out  3  current state encoding, for debug and bench checks

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST.
- Reset values: State = STOPPED, last_dir = DOWN, counter = 0, request registers = 0, UP_M = 0, DN_M = 0, Fault = 0.
- State encoding: CLOSED = 0, OPENING = 1, OPEN = 2, CLOSING = 3, STOPPED = 4, FAULT = 5. Codes 6 and 7 go to FAULT.
- Request generation:
  - req_lvl = Btn_Wall | Btn_Remote, registered once as req_q.
  - req = req_lvl & ~req_q, a one-cycle pulse on the rising edge of the OR.
  - Both buttons pressed together, or a second button pressed while the first is held, produce one request only.
- Latency: if req_lvl first samples high at posedge k, the state changes at posedge k. The motor output reflects the new state immediately after that edge.
- Limit switches and Obstruct are used as sampled, with no synchronizer.
- Outputs are Moore, decoded from State: UP_M = (State == OPENING), DN_M = (State == CLOSING), Fault = (State == FAULT). UP_M and DN_M are never both 1.
- Counter: cleared on entry to OPENING, CLOSING or OPEN, and increments every cycle while in those states. Saturates at all-ones.
- Transitions, priority top-down within each state:
  - Any state except FAULT: UP_Max & DN_Max -> FAULT.
  - STOPPED: req -> OPENING if last_dir == DOWN, else CLOSING.
  - CLOSED: req & ~UP_Max -> OPENING.
  - OPENING:
    - UP_Max -> OPEN.
    - counter == TRAVEL_TIMEOUT-1 -> FAULT.
    - req -> STOPPED with last_dir = UP.
  - OPEN: req -> CLOSING.
  - CLOSING:
    - DN_Max -> CLOSED.
    - Obstruct -> OPENING (auto-reverse; wins over req and timeout).
    - counter == TRAVEL_TIMEOUT-1 -> FAULT.
    - req -> STOPPED with last_dir = DOWN.
  - FAULT: stays until RST is asserted. Buttons are ignored.
- Obstruct in OPENING, OPEN, CLOSED or STOPPED has no effect. Obstruct also blocks the auto-close timer (see Optional Feature).
- Reset asserted mid-travel: motors drop asynchronously and the block returns to STOPPED with last_dir = DOWN, so the next request opens.

Optional Feature:
- Macro: DOOR_AUTO_CLOSE_EN.
- Defined:
  - In OPEN, when counter == AUTO_CLOSE_CYC-1 and Obstruct == 0, go to CLOSING.
  - While Obstruct == 1 in OPEN, the counter is held at 0.
  - A req in OPEN still closes immediately.
- Undefined: OPEN holds indefinitely until req. The counter still runs but is unused.

Test Plan (TRAVEL_TIMEOUT = 8, AUTO_CLOSE_CYC = 6):
- Reset, then pulse Btn_Wall for 1 cycle -> State 4→1, UP_M = 1. Raise UP_Max after 3 cycles -> State = 2, UP_M = 0. Pulse Btn_Remote -> State = 3, DN_M = 1. Raise DN_Max -> State = 0, DN_M = 0.
- In CLOSING, assert Obstruct for 1 cycle -> State = 1 on that edge, UP_M = 1, DN_M = 0.
- In OPENING, press Btn_Wall and Btn_Remote on the same cycle and hold both for 5 cycles -> exactly one transition to STOPPED. A later press -> CLOSING.
- Press a button and never assert a limit -> FAULT exactly 8 cycles after entering OPENING, Fault = 1, motors 0. Further presses ignored; RST low -> State = 4, Fault = 0.
- Assert UP_Max and DN_Max together in any state -> FAULT next edge, both motors 0.
- With DOOR_AUTO_CLOSE_EN: reach OPEN, no buttons -> CLOSING after 6 cycles. With Obstruct held high -> remains OPEN. Without the macro -> remains OPEN for 50 cycles.
